// File: rtl/rf_scoreboard.sv
// Register-file hazard scoreboard: counts in-flight writes per register from issue to writeback and stalls conflicting issue.
// Optional RF_SCOREBOARD_ZERO_REG_EN treats register 0 as hardwired zero (never tracked, never hazards).
module rf_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CW   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [5:0]      issue_op,
    input  logic [AW-1:0]   issue_dst,
    input  logic [AW-1:0]   issue_src1,
    input  logic [AW-1:0]   issue_src2,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_dst,
    output logic            stall,
    output logic            issue_accept,
    output logic [NREG-1:0] pending,
    output logic [AW:0]     inflight,
    output logic            err
);

`ifdef RF_SCOREBOARD_ZERO_REG_EN
    localparam logic ZERO_REG = 1'b1;
`else
    localparam logic ZERO_REG = 1'b0;
`endif

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [AW:0]   INF_MAX = '1;

    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic [NREG-1:0] pending_q, pending_d;
    logic [AW:0]     inflight_q, inflight_d;
    logic            err_q, err_d;

    logic writes_rf, is_store, is_nop;
    logic use_src1, use_src2;
    logic src1_haz, src2_haz, src_haz, sat_haz, cap_haz;
    logic dst_tracked, wb_tracked;
    logic inc_any, dec_any;

    // Opcode classes shared with the writeback-enable decode.
    always_comb begin
        writes_rf = (issue_op == 6'd1) || (issue_op == 6'd2) ||
                    ((issue_op >= 6'd4) && (issue_op <= 6'd20));
        is_store  = (issue_op == 6'd3);
        is_nop    = (issue_op == 6'd0);
        use_src1  = ~is_nop;
        use_src2  = writes_rf | is_store;
    end

    always_comb begin
        src1_haz = use_src1 && (cnt_q[issue_src1] != '0) &&
                   !(ZERO_REG && (issue_src1 == '0));
        src2_haz = use_src2 && (cnt_q[issue_src2] != '0) &&
                   !(ZERO_REG && (issue_src2 == '0));
        src_haz  = src1_haz | src2_haz;
        sat_haz  = writes_rf && (cnt_q[issue_dst] == CNT_MAX);
        cap_haz  = writes_rf && (inflight_q == INF_MAX);
        stall        = issue_valid & ~is_nop & (src_haz | sat_haz | cap_haz);
        issue_accept = issue_valid & ~stall;
    end

    // A writeback in the same cycle does not bypass: hazards look only at cnt_q.
    always_comb begin
        dst_tracked = writes_rf && !(ZERO_REG && (issue_dst == '0));
        wb_tracked  = wb_we && !(ZERO_REG && (wb_dst == '0));
        inc_any     = issue_accept & dst_tracked;
        dec_any     = wb_tracked && (cnt_q[wb_dst] != '0);
        err_d       = err_q | (wb_tracked && (cnt_q[wb_dst] == '0));

        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_any && (issue_dst == AW'(i)) && !(dec_any && (wb_dst == AW'(i))))
                cnt_d[i] = cnt_q[i] + CW'(1);
            else if (dec_any && (wb_dst == AW'(i)) && !(inc_any && (issue_dst == AW'(i))))
                cnt_d[i] = cnt_q[i] - CW'(1);
            pending_d[i] = (cnt_d[i] != '0);
        end

        inflight_d = inflight_q;
        if (inc_any && !dec_any && (inflight_q != INF_MAX))
            inflight_d = inflight_q + 1'b1;
        else if (dec_any && !inc_any && (inflight_q != '0))
            inflight_d = inflight_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
            pending_q  <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign pending  = pending_q;
    assign inflight = inflight_q;
    assign err      = err_q;

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Register-file hazard interlock for the pipelined RISC core; this is the reader side of register-file writeback.
- Sits at decode/issue and tracks every destination register with a write in flight, from issue until writeback asserts RF_WE.
- Stalls issue of any instruction whose sources or destination conflict with pending writes.
- Uses the same 6-bit opcode classes as the writeback-enable decode, so both ends agree on which instructions write the register file.

Parameters:
- NREG, 32, number of architectural registers.
- AW, 5, register index width; clog2(NREG).
- CW, 2, width of each per-register in-flight counter; max in-flight writes per register = 2^CW-1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- issue_valid  input  1  decode stage presents an instruction.
- issue_op  input  6  opcode of the presented instruction.
- issue_dst  input  AW  destination register.
- issue_src1  input  AW  source register 1.
- issue_src2  input  AW  source register 2.
- wb_we  input  1  writeback RF write enable (RF_WE).
- wb_dst  input  AW  writeback destination register.
- stall  output  1  combinational; holds decode.
- issue_accept  output  1  combinational; issue_valid & ~stall.
- pending  output  NREG  registered; bit i = counter i nonzero.
- inflight  output  AW+1  registered; total writes in flight, saturates at all-ones.
- err  output  1  registered, sticky; set on a writeback to a non-pending register.

Behaviour:
- Opcode classes:
  - writes_rf = op in {1,2,4..20}.
  - is_store = (op==3).
  - is_nop = (op==0).
  - all other opcodes are branch-class.
- Sources used:
  - writes_rf: src1 and src2.
  - store: src1 (address) and src2 (data).
  - branch-class: src1 only.
  - NOP: none.
- State: NREG counters cnt[i] of CW bits; inflight; err.
- Reset: all cnt=0, pending=0, inflight=0, err=0. Reset asserted mid-operation clears all state immediately; the bench re-applies writebacks only after release.
- Hazard terms:
  - src_haz = a used source has cnt!=0.
  - sat_haz = writes_rf & cnt[issue_dst]==2^CW-1.
  - cap_haz = writes_rf & inflight all-ones.
- stall = issue_valid & ~is_nop & (src_haz | sat_haz | cap_haz).
- stall is not gated by wb_we in the same cycle: a same-cycle writeback does not bypass. The source unstalls one cycle after its writeback edge.
- inc_i = issue_accept & writes_rf & issue_dst==i.
- dec_i = wb_we & wb_dst==i & cnt[i]!=0.
- Counter update each edge: cnt[i] <= cnt[i] + inc_i - dec_i. inc and dec on the same register in the same cycle: the counter is unchanged.
- inflight <= inflight + (any inc) - (any dec); it never wraps.
- wb_we with cnt[wb_dst]==0: no decrement; err <= 1 and stays set until reset.
- Stores and branch-class instructions are accepted without touching counters (DM_WE side needs no tracking).
- Latency:
  - pending bit rises on the edge that accepts the writer.
  - pending bit falls on the edge of the last matching writeback.

Optional Feature:
- Macro: RF_SCOREBOARD_ZERO_REG_EN.
- Defined:
  - register 0 is hardwired zero.
  - cnt[0] is never incremented.
  - sources equal to 0 never hazard.
  - pending[0] is tied to 0.
  - wb_we to register 0 is ignored and does not set err.
- Undefined: register 0 is tracked like every other register.

Test Plan:
- Reset then issue op=1, dst=5, src=1,2 -> issue_accept=1, stall=0; next cycle pending[5]=1, inflight=1.
- With r5 pending, issue op=2 src1=5 -> stall=1 until the cycle after wb_we=1, wb_dst=5; then accept, pending[5]=0.
- Issue three writers to r7 back-to-back (CW=2) -> cnt[7]=3, fourth writer to r7 stalls; one wb to r7 -> fourth accepted the next cycle, cnt stays 3.
- Same cycle: accept writer dst=9 with wb_we, wb_dst=9 (cnt[9]=1) -> cnt[9] stays 1, inflight unchanged, err=0.
- wb_we, wb_dst=12 with r12 not pending -> err=1 next cycle, stays 1; assert reset mid-run -> err, pending, inflight all 0 asynchronously.
- Store op=3 src2=4 with r4 pending -> stall=1; op=0 with any fields -> never stalls. With RF_SCOREBOARD_ZERO_REG_EN, writer dst=0 then reader src1=0 -> no stall, pending[0]=0.
